// File: rtl/rv_inst_decoder.sv
// rv_inst_decoder: RV32I instruction decoder feeding a small in-order output FIFO
module rv_inst_decoder #(
  parameter int WORD_SIZE = 32,
  parameter int FIFO_DEPTH = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WORD_SIZE-1:0] in_instr,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [5:0]           out_inst,
  output logic [4:0]           out_rs1,
  output logic [4:0]           out_rs2,
  output logic [4:0]           out_rd,
  output logic [WORD_SIZE-1:0] out_imm,
  output logic                 out_illegal,
  output logic [31:0]          inst_count
);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  typedef enum logic [5:0] {
    ADDI, SLTI, SLTIU, ORI, XORI, ANDI, SLLI, SRLI, SRAI, JALR,
    LW, LB, LH, LBU, LHU,
    ADD, SUB, SLL, SLT, SLTU, XOR, SRL, SRA, OR, AND,
    LUI, AUIPC, JAL, SW, SB, SH,
    BEQ, BNE, BLT, BLTU, BGE, BGEU, NO_INST
  } inst_t;
  typedef enum logic [2:0] {F_R, F_I, F_SH, F_S, F_B, F_U, F_J} fmt_t;
  typedef struct packed {
    logic [5:0]           inst;
    logic [4:0]           rs1;
    logic [4:0]           rs2;
    logic [4:0]           rd;
    logic [WORD_SIZE-1:0] imm;
    logic                 illegal;
  } entry_t;
  inst_t code;
  fmt_t fmt;
  entry_t dec;
  entry_t mem [FIFO_DEPTH];
  logic [PW-1:0] wp, rp;
  logic [CW-1:0] count;
  logic push, pop, ill, f7_z, f7_alt;
  logic [2:0] f3;
  assign f3 = in_instr[14:12];
  assign f7_z = in_instr[31:25] == 7'b0000000;
  assign f7_alt = in_instr[31:25] == 7'b0100000;
  // Map opcode, funct3 and funct7 onto an instruction code and its operand format
  always_comb begin
    code = NO_INST;
    fmt = F_R;
    case (in_instr[6:0])
      7'b0010011: begin
        fmt = (f3 == 3'd1 || f3 == 3'd5) ? F_SH : F_I;
        case (f3)
          3'd0: code = ADDI;
          3'd1: code = f7_z ? SLLI : NO_INST;
          3'd2: code = SLTI;
          3'd3: code = SLTIU;
          3'd4: code = XORI;
          3'd5: code = f7_z ? SRLI : (f7_alt ? SRAI : NO_INST);
          3'd6: code = ORI;
          default: code = ANDI;
        endcase
      end
      7'b1100111: begin
        fmt = F_I;
        code = f3 == 3'd0 ? JALR : NO_INST;
      end
      7'b0000011: begin
        fmt = F_I;
        case (f3)
          3'd0: code = LB;
          3'd1: code = LH;
          3'd2: code = LW;
          3'd4: code = LBU;
          3'd5: code = LHU;
          default: code = NO_INST;
        endcase
      end
      7'b0110011: begin
        case (f3)
          3'd0: code = f7_z ? ADD : (f7_alt ? SUB : NO_INST);
          3'd1: code = f7_z ? SLL : NO_INST;
          3'd2: code = f7_z ? SLT : NO_INST;
          3'd3: code = f7_z ? SLTU : NO_INST;
          3'd4: code = f7_z ? XOR : NO_INST;
          3'd5: code = f7_z ? SRL : (f7_alt ? SRA : NO_INST);
          3'd6: code = f7_z ? OR : NO_INST;
          default: code = f7_z ? AND : NO_INST;
        endcase
      end
      7'b0110111: begin
        fmt = F_U;
        code = LUI;
      end
      7'b0010111: begin
        fmt = F_U;
        code = AUIPC;
      end
      7'b1101111: begin
        fmt = F_J;
        code = JAL;
      end
      7'b0100011: begin
        fmt = F_S;
        case (f3)
          3'd0: code = SB;
          3'd1: code = SH;
          3'd2: code = SW;
          default: code = NO_INST;
        endcase
      end
      7'b1100011: begin
        fmt = F_B;
        case (f3)
          3'd0: code = BEQ;
          3'd1: code = BNE;
          3'd4: code = BLT;
          3'd5: code = BGE;
          3'd6: code = BLTU;
          3'd7: code = BGEU;
          default: code = NO_INST;
        endcase
      end
      default: code = NO_INST;
    endcase
  end
  assign ill = code == NO_INST;
  // Zero the register fields a format does not use and build its immediate
  always_comb begin
    dec.inst = code;
    dec.illegal = ill;
    dec.rd = (ill || fmt == F_S || fmt == F_B) ? 5'd0 : in_instr[11:7];
    dec.rs1 = (ill || fmt == F_U || fmt == F_J) ? 5'd0 : in_instr[19:15];
    dec.rs2 = (!ill && (fmt == F_R || fmt == F_S || fmt == F_B)) ? in_instr[24:20] : 5'd0;
    dec.imm = ill ? '0 :
              fmt == F_I  ? WORD_SIZE'($signed(in_instr[31:20])) :
              fmt == F_SH ? WORD_SIZE'(in_instr[24:20]) :
              fmt == F_S  ? WORD_SIZE'($signed({in_instr[31:25], in_instr[11:7]})) :
              fmt == F_B  ? WORD_SIZE'($signed({in_instr[31], in_instr[7], in_instr[30:25], in_instr[11:8], 1'b0})) :
              fmt == F_U  ? WORD_SIZE'({in_instr[31:12], 12'b0}) :
              fmt == F_J  ? WORD_SIZE'($signed({in_instr[31], in_instr[19:12], in_instr[20], in_instr[30:21], 1'b0})) :
              '0;
  end
  assign in_ready = !rst && count != CW'(FIFO_DEPTH);
  assign out_valid = count != '0;
  assign push = in_valid && in_ready;
  assign pop = out_valid && out_ready;
  assign out_inst = mem[rp].inst;
  assign out_rs1 = mem[rp].rs1;
  assign out_rs2 = mem[rp].rs2;
  assign out_rd = mem[rp].rd;
  assign out_imm = mem[rp].imm;
  assign out_illegal = mem[rp].illegal;
  // Pointer, occupancy and popped-item bookkeeping
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wp <= '0;
      rp <= '0;
      count <= '0;
      inst_count <= '0;
    end else begin
      if (push) wp <= wp + PW'(1);
      if (pop) rp <= rp + PW'(1);
      count <= count + CW'(push) - CW'(pop);
      if (pop) inst_count <= inst_count + 32'd1;
    end
  end
  // Entry storage needs no reset: a slot is only read once count covers it
  always_ff @(posedge clk) begin
    if (push) mem[wp] <= dec;
  end
endmodule

// File: tb/tb_rv_inst_decoder.sv
// tb_rv_inst_decoder: scoreboard bench for the RV32I decoder and its output FIFO
module tb_rv_inst_decoder;
  typedef struct packed {
    logic [5:0]  inst;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [31:0] imm;
    logic        ill;
  } exp_t;
  logic clk = 0, rst = 1, in_valid = 0, out_ready = 0;
  logic [31:0] in_instr = '0;
  logic in_ready, out_valid, out_illegal;
  logic [5:0] out_inst;
  logic [4:0] out_rs1, out_rs2, out_rd;
  logic [31:0] out_imm, inst_count;
  int errors = 0, checks = 0;
  exp_t q [$];

  always #5 clk = ~clk;

  rv_inst_decoder dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr),
    .out_valid(out_valid), .out_ready(out_ready), .out_inst(out_inst), .out_rs1(out_rs1),
    .out_rs2(out_rs2), .out_rd(out_rd), .out_imm(out_imm), .out_illegal(out_illegal),
    .inst_count(inst_count)
  );

  function automatic exp_t mk(int inst, int rs1, int rs2, int rd, logic [31:0] imm, bit ill);
    return {6'(inst), 5'(rs1), 5'(rs2), 5'(rd), imm, ill};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  // Monitor: every handshake-completing head item is compared with the oldest expectation
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      exp_t a, e;
      a = {out_inst, out_rs1, out_rs2, out_rd, out_imm, out_illegal};
      checks++;
      if (q.size() == 0) begin
        errors++;
        $display("FAIL pop_unexpected: got inst=%0d with nothing expected", out_inst);
      end else begin
        e = q.pop_front();
        if (a !== e) begin
          errors++;
          $display("FAIL item: got inst=%0d rs1=%0d rs2=%0d rd=%0d imm=%h ill=%b expected inst=%0d rs1=%0d rs2=%0d rd=%0d imm=%h ill=%b",
                   a.inst, a.rs1, a.rs2, a.rd, a.imm, a.ill, e.inst, e.rs1, e.rs2, e.rd, e.imm, e.ill);
        end
      end
    end
  end

  task automatic send(input logic [31:0] w, input exp_t e);
    int t = 0;
    in_valid = 1;
    in_instr = w;
    while (!in_ready && t < 100) begin
      @(posedge clk);
      #1;
      t++;
    end
    chk("accept_wait", in_ready, 1);
    if (in_ready) q.push_back(e);
    @(posedge clk);
    #1;
    in_valid = 0;
  endtask

  task automatic drain();
    for (int t = 0; t < 100 && (out_valid || q.size() != 0); t++) begin
      @(posedge clk);
      #1;
    end
    chk("drain", 32'(out_valid || q.size() != 0), 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_inst_count", inst_count, 0);
    rst = 0;
    @(posedge clk);
    #1;
    chk("ready_after_rst", in_ready, 1);
    // Back-pressure burst: two accepts fill the buffer, third word waits
    in_valid = 1;
    in_instr = 32'h402081B3;
    q.push_back(mk(16, 1, 2, 3, 32'h0, 0));
    @(posedge clk);
    #1;
    in_instr = 32'h40735293;
    q.push_back(mk(8, 6, 0, 5, 32'h7, 0));
    @(posedge clk);
    #1;
    chk("full_in_ready", in_ready, 0);
    chk("full_out_valid", out_valid, 1);
    in_instr = 32'hFE20AC23;
    @(posedge clk);
    #1;
    chk("full_hold_ready", in_ready, 0);
    out_ready = 1;
    #1;
    chk("ready_no_comb_path", in_ready, 0);
    @(posedge clk);
    #1;
    chk("ready_after_pop", in_ready, 1);
    q.push_back(mk(28, 1, 2, 0, 32'hFFFFFFF8, 0));
    @(posedge clk);
    #1;
    in_valid = 0;
    drain();
    chk("burst_inst_count", inst_count, 3);
    // Directed decode vectors
    send(32'h00500093, mk(0, 0, 0, 1, 32'h5, 0));
    chk("latency_out_valid", out_valid, 1);
    send(32'hFE208EE3, mk(31, 1, 2, 0, 32'hFFFFFFFC, 0));
    send(32'h123452B7, mk(25, 0, 0, 5, 32'h12345000, 0));
    send(32'hFFFFFFFF, mk(37, 0, 0, 0, 32'h0, 1));
    send(32'h008000EF, mk(27, 0, 0, 1, 32'h8, 0));
    send(32'hFFF24183, mk(13, 4, 0, 3, 32'hFFFFFFFF, 0));
    send(32'h000100E7, mk(9, 2, 0, 1, 32'h0, 0));
    send(32'h000110E7, mk(37, 0, 0, 0, 32'h0, 1));
    send(32'h02009093, mk(37, 0, 0, 0, 32'h0, 1));
    send(32'h00000001, mk(37, 0, 0, 0, 32'h0, 1));
    send(32'h00002063, mk(37, 0, 0, 0, 32'h0, 1));
    drain();
    chk("total_inst_count", inst_count, 14);
    // Fill the buffer, then reset: buffered entries must vanish
    out_ready = 0;
    in_valid = 1;
    in_instr = 32'h00500093;
    @(posedge clk);
    #1;
    in_instr = 32'hFE208EE3;
    @(posedge clk);
    #1;
    in_valid = 0;
    chk("prefill_full", in_ready, 0);
    rst = 1;
    #1;
    chk("async_rst_out_valid", out_valid, 0);
    chk("async_rst_inst_count", inst_count, 0);
    chk("async_rst_in_ready", in_ready, 0);
    @(posedge clk);
    #1;
    rst = 0;
    @(posedge clk);
    #1;
    chk("post_rst_in_ready", in_ready, 1);
    chk("post_rst_out_valid", out_valid, 0);
    out_ready = 1;
    send(32'h123452B7, mk(25, 0, 0, 5, 32'h12345000, 0));
    drain();
    chk("post_rst_inst_count", inst_count, 1);
    chk("scoreboard_empty", q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/rv_inst_decoder.md
RV_INST_DECODER -- requirements
Module: rv_inst_decoder

Interface
REQ-001 SHALL have parameter WORD_SIZE, default 32, giving the instruction and immediate width.
REQ-002 SHALL have parameter FIFO_DEPTH, default 2, giving the number of output buffer entries; legal values are powers of two, 2 or more.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-005 SHALL have port in_valid, input, 1 bit: in_instr holds a word to decode.
REQ-006 SHALL have port in_ready, output, 1 bit: the block accepts a word this cycle.
REQ-007 SHALL have port in_instr, input, WORD_SIZE bits: raw RV32I instruction word.
REQ-008 SHALL have port out_valid, output, 1 bit: the head buffer entry holds a decoded item.
REQ-009 SHALL have port out_ready, input, 1 bit: the consumer takes the head entry.
REQ-010 SHALL have port out_inst, output, 6 bits: instruction code.
REQ-011 SHALL have ports out_rs1, out_rs2 and out_rd, each output, 5 bits: register indices.
REQ-012 SHALL have port out_imm, output, WORD_SIZE bits: expanded immediate.
REQ-013 SHALL have port out_illegal, output, 1 bit: the head entry was not a legal RV32I instruction.
REQ-014 SHALL have port inst_count, output, 32 bits: number of items popped since reset.

Function
REQ-015 SHALL assign out_inst codes 0..37 in this order: ADDI, SLTI, SLTIU, ORI, XORI, ANDI, SLLI, SRLI, SRAI, JALR, LW, LB, LH, LBU, LHU, ADD, SUB, SLL, SLT, SLTU, XOR, SRL, SRA, OR, AND, LUI, AUIPC, JAL, SW, SB, SH, BEQ, BNE, BLT, BLTU, BGE, BGEU, NO_INST.
REQ-016 SHALL accept a word when in_valid and in_ready are both 1 at a rising edge.
REQ-017 SHALL decode combinationally on accept and push the result into the FIFO tail in the same edge.
REQ-018 SHALL give 1-cycle latency: from an empty FIFO, out_valid rises on the edge after the accept edge.
REQ-019 SHALL pop the head entry when out_valid and out_ready are both 1 at a rising edge.
REQ-020 SHALL drive in_ready = (count != FIFO_DEPTH) from registered count, with no combinational path from out_ready; when full, a pop frees space only for the next cycle.
REQ-021 SHALL, on simultaneous push and pop while not full or empty, keep count unchanged and preserve FIFO order.
REQ-022 SHALL let read and write pointers wrap modulo FIFO_DEPTH.
REQ-023 SHALL drive the head entry fields on out_*; when out_valid is 0 those fields are don't-care.
REQ-024 SHALL hold out_valid = (count != 0).
REQ-025 SHALL form immediates as follows:
- I-type: sext(instr[31:20]).
- Shifts (SLLI, SRLI, SRAI): zero-extended instr[24:20].
- S-type: sext({instr[31:25], instr[11:7]}).
- B-type: sext({instr[31], instr[7], instr[30:25], instr[11:8], 0}).
- U-type: {instr[31:12], 12'b0}.
- J-type: sext({instr[31], instr[19:12], instr[20], instr[30:21], 0}).
- R-type: imm = 0.
REQ-026 SHALL force rs1, rs2 and rd to 0 for any field the instruction format does not use.
REQ-027 SHALL flag illegal, with out_inst=NO_INST, rs1/rs2/rd/imm=0 and out_illegal=1, for any of:
- instr[1:0] != 2'b11.
- Unknown opcode.
- Unused funct3 value.
- R-type funct7 not 0000000, or not 0100000 for SUB/SRA.
- SLLI/SRLI with instr[31:25] != 0, or SRAI with instr[31:25] != 0100000.
- JALR with funct3 != 0.
REQ-028 SHALL increment inst_count by 1 per pop, illegal items included, wrapping from 2^32-1 to 0.

Reset
REQ-029 SHALL, while rst=1, force count=0, both pointers=0, out_valid=0, in_ready=0 and inst_count=0; buffered entries are discarded.
REQ-030 SHALL raise in_ready to 1 in the first cycle after rst deasserts.
REQ-031 SHALL, if rst asserts mid-transfer, drop any accept or pop in flight at that edge and take no further action.

Verification
REQ-032 Bench SHALL cover: push 0x00500093 -> one cycle later out_inst=0 (ADDI), rd=1, rs1=0, rs2=0, imm=0x00000005, out_illegal=0.
REQ-033 Bench SHALL cover: push 0xFE208EE3 -> out_inst=31 (BEQ), rs1=1, rs2=2, rd=0, imm=0xFFFFFFFC.
REQ-034 Bench SHALL cover: push 0x123452B7 -> out_inst=25 (LUI), rd=5, imm=0x12345000; then push 0xFFFFFFFF -> out_inst=37, out_illegal=1, imm=0.
REQ-035 Bench SHALL cover: out_ready=0, in_valid=1 for 3 distinct words -> in_ready=0 after 2 accepts; raise out_ready -> in_ready=1 the next cycle; all 3 items emerge in order; inst_count=3.
REQ-036 Bench SHALL cover: FIFO full, assert rst for 1 cycle -> out_valid=0, inst_count=0 immediately; in_ready=1 the cycle after release; the next push yields only that new item.
